ysyx_25030093_lsu: RTL and testbench

YSYX_25030093_LSU -- requirements
Module: ysyx_25030093_lsu

---
 rtl/ysyx_25030093_pkg.sv | 47 ++++
 rtl/ysyx_25030093_lsu_align.sv | 80 ++++++++
 rtl/ysyx_25030093_lsu.sv | 159 +++++++++++++++
 tb/tb_ysyx_25030093_lsu.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25030093_pkg.sv
// ysyx_25030093_pkg
// Shared definitions for the load/store unit: memory-operation encodings,
// the LSU FSM state type, and small helpers that classify an operation.
// Codes 9-15 are not listed and are treated like MEM_OP_NONE everywhere.
package ysyx_25030093_pkg;

    localparam logic [3:0] MEM_OP_NONE = 4'd0;
    localparam logic [3:0] MEM_OP_LB   = 4'd1;
    localparam logic [3:0] MEM_OP_LH   = 4'd2;
    localparam logic [3:0] MEM_OP_LW   = 4'd3;
    localparam logic [3:0] MEM_OP_LBU  = 4'd4;
    localparam logic [3:0] MEM_OP_LHU  = 4'd5;
    localparam logic [3:0] MEM_OP_SB   = 4'd6;
    localparam logic [3:0] MEM_OP_SH   = 4'd7;
    localparam logic [3:0] MEM_OP_SW   = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } lsu_state_e;

    function automatic logic op_is_load(input logic [3:0] op);
        return (op == MEM_OP_LB) || (op == MEM_OP_LH) || (op == MEM_OP_LW) ||
               (op == MEM_OP_LBU) || (op == MEM_OP_LHU);
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
    endfunction

    function automatic logic op_is_mem(input logic [3:0] op);
        return op_is_load(op) || op_is_store(op);
    endfunction

    // Halfword accesses need addr[0]==0, word accesses need addr[1:0]==0;
    // byte accesses and non-memory ops can never be misaligned.
    function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] addr_lo);
        logic is_half;
        logic is_word;
        is_half = (op == MEM_OP_LH) || (op == MEM_OP_LHU) || (op == MEM_OP_SH);
        is_word = (op == MEM_OP_LW) || (op == MEM_OP_SW);
        return (is_half && addr_lo[0]) || (is_word && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/ysyx_25030093_lsu_align.sv
// ysyx_25030093_lsu_align
// Purely combinational lane logic for the LSU.
//   mem_op      : operation code (see ysyx_25030093_pkg)
//   addr_lo     : low two address bits selecting the byte/halfword lane
//   store_data  : raw store operand (rs2)
//   load_word   : full 32-bit word returned by memory
//   is_load     : op is a load
//   is_store    : op is a store
//   wstrb       : byte write strobes (0 for anything that is not a store)
//   wdata       : store data replicated across all lanes
//   load_data   : extracted and extended load result (0 for non-loads)
module ysyx_25030093_lsu_align
    import ysyx_25030093_pkg::*;
(
    input  logic [3:0]  mem_op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic        is_load,
    output logic        is_store,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    function automatic logic [31:0] sext8(input logic signed [7:0] b);
        logic signed [31:0] ext;
        ext = b;
        return ext;
    endfunction

    function automatic logic [31:0] sext16(input logic signed [15:0] h);
        logic signed [31:0] ext;
        ext = h;
        return ext;
    endfunction

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        is_load  = op_is_load(mem_op);
        is_store = op_is_store(mem_op);

        unique case (addr_lo)
            2'd0:    ld_byte = load_word[7:0];
            2'd1:    ld_byte = load_word[15:8];
            2'd2:    ld_byte = load_word[23:16];
            default: ld_byte = load_word[31:24];
        endcase
        ld_half = addr_lo[1] ? load_word[31:16] : load_word[15:0];

        load_data = 32'd0;
        wstrb     = 4'b0000;
        wdata     = 32'd0;
        case (mem_op)
            MEM_OP_LB:  load_data = sext8(ld_byte);
            MEM_OP_LH:  load_data = sext16(ld_half);
            MEM_OP_LW:  load_data = load_word;
            MEM_OP_LBU: load_data = {24'd0, ld_byte};
            MEM_OP_LHU: load_data = {16'd0, ld_half};
            // Store data is replicated into every lane so the strobes alone
            // decide which bytes memory actually updates.
            MEM_OP_SB: begin
                wstrb = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            MEM_OP_SH: begin
                wstrb = 4'b0011 << addr_lo;
                wdata = {2{store_data[15:0]}};
            end
            MEM_OP_SW: begin
                wstrb = 4'b1111;
                wdata = store_data;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ysyx_25030093_lsu.sv
// ysyx_25030093_lsu
// Single-outstanding load/store unit between execute and writeback.
// An operation is latched in IDLE, optionally issues one memory request
// (REQ), waits for the response or write acknowledge (WAIT), then presents
// the writeback result (DONE) until the consumer takes it.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : execute-side handshake
//   in_addr, in_wdata     : effective address (or pass-through result), store data
//   in_mem_op             : operation code, in_rd_idx / in_rf_wen : destination
//   mem_req_*             : word-aligned memory request with lane strobes
//   mem_resp_valid/rdata  : memory response (read data or write acknowledge)
//   out_valid/out_ready   : writeback-side handshake
//   out_rd_data, out_rd_idx, out_rf_wen, out_misalign : writeback result
module ysyx_25030093_lsu
    import ysyx_25030093_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [3:0]  in_mem_op,
    input  logic [4:0]  in_rd_idx,
    input  logic        in_rf_wen,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    output logic        mem_req_wen,
    output logic [3:0]  mem_req_wstrb,
    output logic [31:0] mem_req_wdata,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rd_data,
    output logic [4:0]  out_rd_idx,
    output logic        out_rf_wen,
    output logic        out_misalign
);

    lsu_state_e  state;
    lsu_state_e  state_nxt;

    logic [3:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [4:0]  rd_idx_q;
    logic        rf_wen_q;

    logic        is_load;
    logic        is_store;
    logic [31:0] load_data;
    logic        misalign_q;

    ysyx_25030093_lsu_align u_align (
        .mem_op     (op_q),
        .addr_lo    (addr_q[1:0]),
        .store_data (wdata_q),
        .load_word  (rdata_q),
        .is_load    (is_load),
        .is_store   (is_store),
        .wstrb      (mem_req_wstrb),
        .wdata      (mem_req_wdata),
        .load_data  (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        in_ready      = 1'b0;
        mem_req_valid = 1'b0;
        out_valid     = 1'b0;
        unique case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // Misaligned and non-memory ops skip the memory entirely.
                    if (op_is_mem(in_mem_op) && !op_misaligned(in_mem_op, in_addr[1:0])) begin
                        state_nxt = S_REQ;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_resp_valid) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Everything the request and the result depend on is frozen here, so the
    // outputs stay stable across any amount of backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= 4'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            rd_idx_q <= 5'd0;
            rf_wen_q <= 1'b0;
        end else begin
            if (state == S_IDLE && in_valid) begin
                op_q     <= in_mem_op;
                addr_q   <= in_addr;
                wdata_q  <= in_wdata;
                rd_idx_q <= in_rd_idx;
                rf_wen_q <= in_rf_wen;
            end
            // Responses are only meaningful while a request is outstanding.
            if (state == S_WAIT && mem_resp_valid) begin
                rdata_q <= mem_resp_rdata;
            end
        end
    end

    assign misalign_q   = op_misaligned(op_q, addr_q[1:0]);

    assign mem_req_addr = {addr_q[31:2], 2'b00};
    assign mem_req_wen  = is_store;

    assign out_rd_idx   = rd_idx_q;
    assign out_misalign = misalign_q;
    assign out_rf_wen   = rf_wen_q && !misalign_q && !is_store && (rd_idx_q != 5'd0);

    always_comb begin
        if (misalign_q || is_store) begin
            out_rd_data = 32'd0;
        end else if (is_load) begin
            out_rd_data = load_data;
        end else begin
            out_rd_data = addr_q;
        end
    end

endmodule

// File: tb/tb_ysyx_25030093_lsu.sv
// tb_ysyx_25030093_lsu
// Directed bench for the LSU with a behavioural expectation model and a
// per-cycle compare process.
module tb_ysyx_25030093_lsu;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [3:0]  in_mem_op;
    logic [4:0]  in_rd_idx;
    logic        in_rf_wen;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [3:0]  mem_req_wstrb;
    logic [31:0] mem_req_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rd_data;
    logic [4:0]  out_rd_idx;
    logic        out_rf_wen;
    logic        out_misalign;

    ysyx_25030093_lsu dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_addr        (in_addr),
        .in_wdata       (in_wdata),
        .in_mem_op      (in_mem_op),
        .in_rd_idx      (in_rd_idx),
        .in_rf_wen      (in_rf_wen),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wen    (mem_req_wen),
        .mem_req_wstrb  (mem_req_wstrb),
        .mem_req_wdata  (mem_req_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_rd_data    (out_rd_data),
        .out_rd_idx     (out_rd_idx),
        .out_rf_wen     (out_rf_wen),
        .out_misalign   (out_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        req;
        logic [31:0] req_addr;
        logic        wen;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] rd_data;
        logic [4:0]  rd_idx;
        logic        rf_wen;
        logic        mis;
        logic        chk_rd;
    } exp_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_cur;
    bit   exp_req_ok  = 1'b0;
    bit   exp_out_ok  = 1'b0;
    bit   exp_in_ready = 1'b1;

    logic [31:0] last_req_addr;
    logic        last_req_wen;
    logic [3:0]  last_req_wstrb;
    logic [31:0] last_req_wdata;
    logic [31:0] last_out_rd_data;
    logic        last_out_rf_wen;
    logic        last_out_mis;
    bit          saw_req;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b, expected %0b", name, act, exp);
        end
    endtask

    // What the LSU must produce for one operation, from the op semantics alone.
    function automatic exp_t model(input int op, input logic [31:0] a, input logic [31:0] wd,
                                   input logic [31:0] word, input logic [4:0] rd, input bit rfw);
        exp_t   e;
        int     lane;
        int     sz;
        bit     ld;
        bit     st;
        bit     sgn;
        longint v;
        e = '0;
        e.chk_rd = 1'b1;
        e.rd_idx = rd;
        lane = int'(a % 4);
        sz = 1; ld = 1'b0; st = 1'b0; sgn = 1'b0;
        case (op)
            1: begin ld = 1'b1; sz = 1; sgn = 1'b1; end
            2: begin ld = 1'b1; sz = 2; sgn = 1'b1; end
            3: begin ld = 1'b1; sz = 4; end
            4: begin ld = 1'b1; sz = 1; end
            5: begin ld = 1'b1; sz = 2; end
            6: begin st = 1'b1; sz = 1; end
            7: begin st = 1'b1; sz = 2; end
            8: begin st = 1'b1; sz = 4; end
            default: ;
        endcase
        if (!ld && !st) begin
            e.rd_data = a;
            e.rf_wen  = rfw && (rd != 5'd0);
            return e;
        end
        if ((lane % sz) != 0) begin
            e.mis = 1'b1;
            return e;
        end
        e.req      = 1'b1;
        e.req_addr = a - 32'(lane);
        if (st) begin
            e.wen   = 1'b1;
            e.wstrb = 4'(((1 << sz) - 1) << lane);
            if (sz == 1)      e.wdata = (wd & 32'hFF) * 32'h01010101;
            else if (sz == 2) e.wdata = (wd & 32'hFFFF) * 32'h00010001;
            else              e.wdata = wd;
            e.chk_rd = 1'b0;
        end else begin
            v = longint'(word >> (8 * lane)) & ((longint'(1) << (8 * sz)) - 1);
            if (sgn && v >= (longint'(1) << (8 * sz - 1)))
                v = v - (longint'(1) << (8 * sz));
            e.rd_data = v[31:0];
            e.rf_wen  = rfw && (rd != 5'd0);
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            check1("in_ready", in_ready, exp_in_ready);
            if (!exp_req_ok) begin
                check1("no_req", mem_req_valid, 1'b0);
            end else if (mem_req_valid) begin
                saw_req        = 1'b1;
                last_req_addr  = mem_req_addr;
                last_req_wen   = mem_req_wen;
                last_req_wstrb = mem_req_wstrb;
                last_req_wdata = mem_req_wdata;
                check32("req_addr", mem_req_addr, exp_cur.req_addr);
                check1("req_wen", mem_req_wen, exp_cur.wen);
                check32("req_wstrb", 32'(mem_req_wstrb), 32'(exp_cur.wstrb));
                check32("req_wdata", mem_req_wdata, exp_cur.wdata);
            end
            if (!exp_out_ok) begin
                check1("no_out", out_valid, 1'b0);
            end else if (out_valid) begin
                last_out_rd_data = out_rd_data;
                last_out_rf_wen  = out_rf_wen;
                last_out_mis     = out_misalign;
                if (exp_cur.chk_rd) check32("out_rd_data", out_rd_data, exp_cur.rd_data);
                check32("out_rd_idx", 32'(out_rd_idx), 32'(exp_cur.rd_idx));
                check1("out_rf_wen", out_rf_wen, exp_cur.rf_wen);
                check1("out_misalign", out_misalign, exp_cur.mis);
            end
        end
    end

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] word, input logic [4:0] rd, input bit rfw,
                          input int req_stall, input int resp_delay, input int out_stall);
        exp_cur    = model(int'(op), a, wd, word, rd, rfw);
        exp_req_ok = exp_cur.req;
        exp_out_ok = 1'b0;
        saw_req    = 1'b0;
        in_valid   = 1'b1;
        in_mem_op  = op;
        in_addr    = a;
        in_wdata   = wd;
        in_rd_idx  = rd;
        in_rf_wen  = rfw;
        if (!exp_cur.req) exp_out_ok = 1'b1;
        @(posedge clk); #1;
        // Scramble the inputs so a design that fails to latch them is caught.
        in_valid  = 1'b0;
        in_addr   = $urandom;
        in_wdata  = $urandom;
        in_mem_op = 4'($urandom_range(0, 15));
        in_rd_idx = 5'($urandom_range(0, 31));
        in_rf_wen = 1'($urandom_range(0, 1));
        exp_in_ready = 1'b0;
        if (exp_cur.req) begin
            check1("req_valid_lat", mem_req_valid, 1'b1);
            for (int k = 0; k < req_stall; k++) begin
                @(posedge clk); #1;
                check1("req_held", mem_req_valid, 1'b1);
            end
            mem_req_ready = 1'b1;
            @(posedge clk); #1;
            mem_req_ready = 1'b0;
            exp_req_ok    = 1'b0;
            for (int k = 0; k < resp_delay; k++) begin
                @(posedge clk); #1;
                check1("wait_no_out", out_valid, 1'b0);
            end
            exp_out_ok     = 1'b1;
            mem_resp_valid = 1'b1;
            mem_resp_rdata = word;
            @(posedge clk); #1;
            mem_resp_valid = 1'b0;
            mem_resp_rdata = $urandom;
        end
        check1("out_valid_lat", out_valid, 1'b1);
        for (int k = 0; k < out_stall; k++) begin
            @(posedge clk); #1;
            check1("out_held", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready    = 1'b0;
        exp_out_ok   = 1'b0;
        exp_in_ready = 1'b1;
        check1("out_drop", out_valid, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check1({tag, "_in_ready"}, in_ready, 1'b1);
        check1({tag, "_req_valid"}, mem_req_valid, 1'b0);
        check32({tag, "_req_addr"}, mem_req_addr, 32'd0);
        check1({tag, "_req_wen"}, mem_req_wen, 1'b0);
        check32({tag, "_req_wstrb"}, 32'(mem_req_wstrb), 32'd0);
        check32({tag, "_req_wdata"}, mem_req_wdata, 32'd0);
        check1({tag, "_out_valid"}, out_valid, 1'b0);
        check32({tag, "_out_rd_data"}, out_rd_data, 32'd0);
        check32({tag, "_out_rd_idx"}, 32'(out_rd_idx), 32'd0);
        check1({tag, "_out_rf_wen"}, out_rf_wen, 1'b0);
        check1({tag, "_out_misalign"}, out_misalign, 1'b0);
    endtask

    initial begin
        rst_n          = 1'b0;
        in_valid       = 1'b0;
        in_addr        = 32'd0;
        in_wdata       = 32'd0;
        in_mem_op      = 4'd0;
        in_rd_idx      = 5'd0;
        in_rf_wen      = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;  // stale response across reset
        mem_resp_rdata = 32'hBAD0BAD0;
        out_ready      = 1'b0;
        exp_cur        = '0;

        // Model pins against hand-computed values.
        exp_cur = model(1, 32'h80000003, 32'd0, 32'h80FF1234, 5'd1, 1'b1);
        check32("model_lb", exp_cur.rd_data, 32'hFFFFFF80);
        exp_cur = model(7, 32'h80000002, 32'h0000ABCD, 32'd0, 5'd1, 1'b1);
        check32("model_sh_wdata", exp_cur.wdata, 32'hABCDABCD);
        check32("model_sh_wstrb", 32'(exp_cur.wstrb), 32'hC);
        exp_cur = '0;

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
        check1("stale_resp_ignored", out_valid, 1'b0);
        check1("stale_resp_idle", in_ready, 1'b1);

        // lw aligned
        run_op(4'd3, 32'h80000004, 32'h11111111, 32'hDEADBEEF, 5'd5, 1'b1, 0, 0, 0);
        check32("lw_req_addr", last_req_addr, 32'h80000004);
        check1("lw_req_wen", last_req_wen, 1'b0);
        check32("lw_req_wstrb", 32'(last_req_wstrb), 32'd0);
        check32("lw_rd_data", last_out_rd_data, 32'hDEADBEEF);
        check1("lw_rf_wen", last_out_rf_wen, 1'b1);

        // lb / lbu lane 3
        run_op(4'd1, 32'h80000003, 32'd0, 32'h80FF1234, 5'd6, 1'b1, 0, 0, 0);
        check32("lb_rd_data", last_out_rd_data, 32'hFFFFFF80);
        run_op(4'd4, 32'h80000003, 32'd0, 32'h80FF1234, 5'd6, 1'b1, 0, 1, 0);
        check32("lbu_rd_data", last_out_rd_data, 32'h00000080);

        // sh upper half
        run_op(4'd7, 32'h80000002, 32'h0000ABCD, 32'd0, 5'd7, 1'b1, 0, 0, 0);
        check32("sh_req_addr", last_req_addr, 32'h80000000);
        check32("sh_req_wstrb", 32'(last_req_wstrb), 32'hC);
        check32("sh_req_wdata", last_req_wdata, 32'hABCDABCD);
        check1("sh_req_wen", last_req_wen, 1'b1);
        check1("sh_rf_wen", last_out_rf_wen, 1'b0);

        // misaligned lw: no request, result next cycle
        run_op(4'd3, 32'h80000002, 32'd0, 32'd0, 5'd8, 1'b1, 0, 0, 0);
        check1("mis_no_req", saw_req, 1'b0);
        check1("mis_flag", last_out_mis, 1'b1);
        check1("mis_rf_wen", last_out_rf_wen, 1'b0);
        check32("mis_rd_data", last_out_rd_data, 32'd0);

        // backpressure on both sides
        run_op(4'd8, 32'h80000008, 32'h12345678, 32'd0, 5'd9, 1'b1, 3, 1, 2);
        check32("sw_req_wdata", last_req_wdata, 32'h12345678);
        check32("sw_req_wstrb", 32'(last_req_wstrb), 32'hF);
        run_op(4'd2, 32'h80000002, 32'd0, 32'h80017FFF, 5'd10, 1'b1, 3, 2, 2);
        check32("lh_rd_data", last_out_rd_data, 32'hFFFF8001);

        // more lanes, non-memory ops, rd==0, other misalignments
        run_op(4'd5, 32'h80000000, 32'd0, 32'h80017FFF, 5'd11, 1'b1, 0, 0, 0);
        check32("lhu_rd_data", last_out_rd_data, 32'h00007FFF);
        run_op(4'd6, 32'h80000001, 32'hCAFE005A, 32'd0, 5'd12, 1'b1, 1, 0, 0);
        check32("sb_req_wstrb", 32'(last_req_wstrb), 32'h2);
        check32("sb_req_wdata", last_req_wdata, 32'h5A5A5A5A);
        run_op(4'd1, 32'h80000000, 32'd0, 32'h000000F0, 5'd13, 1'b0, 0, 0, 0);
        run_op(4'd0, 32'h00001234, 32'd0, 32'd0, 5'd3, 1'b1, 0, 0, 0);
        check32("none_rd_data", last_out_rd_data, 32'h00001234);
        run_op(4'd12, 32'hFEDCBA98, 32'd0, 32'd0, 5'd4, 1'b1, 0, 0, 1);
        run_op(4'd3, 32'h80000010, 32'd0, 32'h55AA55AA, 5'd0, 1'b1, 0, 0, 0);
        check1("rd0_rf_wen", last_out_rf_wen, 1'b0);
        run_op(4'd0, 32'h00000077, 32'd0, 32'd0, 5'd0, 1'b1, 0, 0, 0);
        run_op(4'd2, 32'h80000001, 32'd0, 32'd0, 5'd14, 1'b1, 0, 0, 0);
        run_op(4'd8, 32'h80000003, 32'h0BADF00D, 32'd0, 5'd15, 1'b1, 0, 0, 0);
        check1("sw_mis_no_req", saw_req, 1'b0);

        // reset while waiting for a response
        exp_cur    = model(3, 32'h80000010, 32'd0, 32'd0, 5'd2, 1'b1);
        exp_req_ok = 1'b1;
        in_valid   = 1'b1;
        in_mem_op  = 4'd3;
        in_addr    = 32'h80000010;
        in_rd_idx  = 5'd2;
        in_rf_wen  = 1'b1;
        @(posedge clk); #1;
        in_valid      = 1'b0;
        exp_in_ready  = 1'b0;
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        exp_req_ok    = 1'b0;
        check1("rstw_in_wait", mem_req_valid, 1'b0);
        @(posedge clk); #1;
        rst_n        = 1'b0;
        exp_in_ready = 1'b1;
        #1;
        check_reset_outputs("rstw");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h13579BDF;
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
        check1("rstw_resp_ignored", out_valid, 1'b0);
        check1("rstw_idle", in_ready, 1'b1);
        @(posedge clk); #1;
        check1("rstw_still_idle", out_valid, 1'b0);

        // normal operation resumes after reset
        run_op(4'd1, 32'h80000002, 32'd0, 32'h007F0000, 5'd20, 1'b1, 0, 0, 0);
        check32("post_rst_lb", last_out_rd_data, 32'h0000007F);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
